// File: rtl/instr_feeder.sv
// Prefetching instruction source for the 16-bit multicycle processor: ROM -> FIFO -> DIN/Run.
// Optional retired-instruction counter enabled by defining INSTR_FEEDER_COUNT_EN.
module instr_feeder #(
  parameter int AW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          Start,
  input  logic          Done,
  input  logic [15:0]   RomQ,
  output logic [AW-1:0] Addr,
  output logic [15:0]   DIN,
  output logic          Run,
  output logic          Halted,
  output logic [AW-1:0] PC,
  output logic [1:0]    dbg_state_o
`ifdef INSTR_FEEDER_COUNT_EN
  ,
  output logic [15:0]   Retired
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_READY, S_BUSY, S_HALT} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic            inflight_q, inflight_d;
  logic            halt_seen_q, halt_seen_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [15:0]     mem_q [DEPTH];

  logic            run_w, pop, flush, push, req, empty, head_halt;
  logic [CW:0]     occ;
  logic [15:0]     head;

  assign head      = mem_q[rd_ptr_q];
  assign head_halt = (head[15:13] == 3'b111);
  assign empty     = (count_q == '0);
  assign occ       = {1'b0, count_q} + (CW+1)'(inflight_q);

  // Handshake: Run is a one-cycle issue strobe; the processor captures DIN on the
  // edge that samples Run, and signals completion with a one-cycle Done while BUSY.
  always_comb begin
    state_d = state_q;
    run_w   = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (Start) begin
          state_d = S_READY;
          flush   = 1'b1;
        end
      end
      S_READY: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_halt) begin
            state_d = S_HALT;
          end else begin
            run_w   = 1'b1;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (Done) state_d = S_READY;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // In-flight word is counted against capacity so the FIFO can never overflow.
  always_comb begin
    req         = ((state_q == S_READY) || (state_q == S_BUSY)) && !halt_seen_q && (occ < DEPTH_L);
    push        = inflight_q && !flush;
    pc_d        = pc_q;
    inflight_d  = req;
    halt_seen_d = halt_seen_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (flush) begin
      pc_d        = '0;
      inflight_d  = 1'b0;
      halt_seen_d = 1'b0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
    end else begin
      if (req) pc_d = pc_q + AW'(1);
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        if (RomQ[15:13] == 3'b111) halt_seen_d = 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      inflight_q  <= 1'b0;
      halt_seen_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inflight_q  <= inflight_d;
      halt_seen_q <= halt_seen_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      if (push) mem_q[wr_ptr_q] <= RomQ;
    end
  end

`ifdef INSTR_FEEDER_COUNT_EN
  logic [15:0] retired_q, retired_d;

  always_comb begin
    retired_d = retired_q;
    if (flush) retired_d = '0;
    else if ((state_q == S_BUSY) && Done && (retired_q != 16'hFFFF)) retired_d = retired_q + 16'd1;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) retired_q <= '0;
    else         retired_q <= retired_d;
  end

  assign Retired = retired_q;
`endif

  assign Addr        = pc_q;
  assign PC          = pc_q;
  assign DIN         = head;
  assign Run         = run_w;
  assign Halted      = (state_q == S_HALT);
  assign dbg_state_o = state_q;

endmodule
